// File: rtl/pcie_7x_rx_lane_deskew_pkg.sv
// Shared constants, FSM encoding and pointer-width helper for the RX lane deskew block.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package pcie_7x_deskew_pkg;

  localparam int         C_SYM_W   = 8;
  localparam logic [7:0] C_COM_SYM = 8'hBC;   // K28.5

  typedef enum logic {
    HUNT    = 1'b0,
    ALIGNED = 1'b1
  } state_e;

  // Bits needed to index v entries; never less than one bit so that
  // single-entry counters still have a legal width.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pcie_7x_rx_lane_deskew_if.sv
// Multi-lane symbol stream: per-lane 8-bit symbol plus K flag, one common beat valid.
// Latency: wires only.
// Backpressure: none; the stream has no ready.
interface pcie_7x_rx_lane_deskew_if #(
  parameter int C_LANES = 4
);
  logic [C_LANES*8-1:0] data;
  logic [C_LANES-1:0]   k;
  logic                 valid;

  modport master (output data, output k, output valid);
  modport slave  (input  data, input  k, input  valid);
endinterface

// File: rtl/pcie_7x_rx_lane_deskew_lane_buf.sv
// One lane's circular symbol buffer with its own read pointer, COM detect and output register.
// Latency: one cycle from read enable to out_data/out_k.
// Backpressure: none; writes every enabled beat, the owner keeps rd_ptr behind wr_addr.
module pcie_7x_deskew_lane_buf
  import pcie_7x_deskew_pkg::*;
#(
  parameter int C_DEPTH = 8,
  parameter int C_PW    = clog2(C_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [C_PW-1:0]    wr_addr,
  input  logic [C_SYM_W-1:0] in_data,
  input  logic               in_k,
  input  logic               rd_load,
  input  logic               rd_en,
  output logic               in_com,
  output logic               rd_com,
  output logic [C_SYM_W-1:0] out_data,
  output logic               out_k
);

  logic [C_SYM_W:0]   mem [C_DEPTH];
  logic [C_PW-1:0]    rd_ptr;
  logic [C_SYM_W:0]   rd_word;

  assign in_com  = in_k && (in_data == C_COM_SYM);
  assign rd_word = mem[rd_ptr];
  assign rd_com  = rd_word[C_SYM_W] && (rd_word[C_SYM_W-1:0] == C_COM_SYM);

  // Every valid beat lands in the buffer regardless of alignment state.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= {in_k, in_data};
  end

  // Read pointer snaps to the COM's slot while hunting, then walks with the stream.
  always_ff @(posedge clk) begin
    if (rst)          rd_ptr <= '0;
    else if (rd_load) rd_ptr <= wr_addr;
    else if (rd_en)   rd_ptr <= rd_ptr + C_PW'(1);
  end

  // Registered lane output; holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_k    <= 1'b0;
    end else if (rd_en) begin
      out_data <= rd_word[C_SYM_W-1:0];
      out_k    <= rd_word[C_SYM_W];
    end
  end

endmodule

// File: rtl/pcie_7x_rx_lane_deskew.sv
// Aligns C_LANES receive lanes on their COM symbols by delaying early lanes in per-lane buffers.
// Latency: 2 cycles for the latest lane, k+2 for a lane k beats early (continuous valid).
// Backpressure: none; an input beat every cycle is absorbed, errors pulse deskew_err.
module pcie_7x_rx_lane_deskew
  import pcie_7x_deskew_pkg::*;
#(
  parameter int C_LANES    = 4,
  parameter int C_DEPTH    = 8,
  parameter int C_MAX_SKEW = 4
) (
  input  logic                       aclk,
  input  logic                       areset,
  pcie_7x_rx_lane_deskew_if.slave    s_rx,
  pcie_7x_rx_lane_deskew_if.master   m_out,
  output logic                       aligned,
  output logic                       deskew_err
);

  localparam int         PW        = clog2(C_DEPTH);
  localparam int         SW        = clog2(C_MAX_SKEW + 1);
  localparam logic [0:0] S_HUNT    = HUNT;
  localparam logic [0:0] S_ALIGNED = ALIGNED;
  localparam logic [SW-1:0] SKEW_MAX = SW'(C_MAX_SKEW);

  logic [0:0]           state;
  logic [PW-1:0]        wr_ptr;
  logic [C_LANES-1:0]   seen;
  logic [SW-1:0]        skew_cnt;
  logic                 m_valid_q;
  logic                 err_q;

  logic [C_LANES-1:0]   com_in;
  logic [C_LANES-1:0]   rd_com;
  logic [C_LANES-1:0]   rd_load;
  logic [C_LANES-1:0]   seen_nxt;
  logic [SW-1:0]        beat_skew;
  logic                 hunting;
  logic                 rd_en;
  logic                 hunt_align;
  logic                 hunt_err;
  logic                 mismatch;
  logic [C_LANES*8-1:0] out_data;
  logic [C_LANES-1:0]   out_k;

  assign hunting   = (state == S_HUNT);
  assign rd_en     = !hunting && s_rx.valid;
  assign seen_nxt  = seen | com_in;
  // Skew of the current beat: 0 on the opening COM, otherwise one past the last beat (saturating).
  assign beat_skew = (seen == '0) ? '0 :
                     (skew_cnt == SKEW_MAX) ? skew_cnt : skew_cnt + SW'(1);
  assign rd_load   = {C_LANES{hunting && s_rx.valid}} & com_in & ~seen;

  assign hunt_align = hunting && s_rx.valid && (&seen_nxt) && (beat_skew <= SKEW_MAX);
  assign hunt_err   = hunting && s_rx.valid && !(&seen_nxt) && (|seen_nxt) &&
                      (beat_skew == SKEW_MAX);
  // Lane 0 is the reference: a COM there must be a COM everywhere.
  assign mismatch   = rd_en && rd_com[0] && !(&rd_com);

  for (genvar n = 0; n < C_LANES; n++) begin : g_lane
    pcie_7x_deskew_lane_buf #(
      .C_DEPTH (C_DEPTH),
      .C_PW    (PW)
    ) u_buf (
      .clk      (aclk),
      .rst      (areset),
      .wr_en    (s_rx.valid),
      .wr_addr  (wr_ptr),
      .in_data  (s_rx.data[8*n +: 8]),
      .in_k     (s_rx.k[n]),
      .rd_load  (rd_load[n]),
      .rd_en    (rd_en),
      .in_com   (com_in[n]),
      .rd_com   (rd_com[n]),
      .out_data (out_data[8*n +: 8]),
      .out_k    (out_k[n])
    );
  end

  // Shared write pointer advances on every valid beat in every state.
  always_ff @(posedge aclk) begin
    if (areset)          wr_ptr <= '0;
    else if (s_rx.valid) wr_ptr <= wr_ptr + PW'(1);
  end

  // Hunt/align FSM with seen mask and skew counter; any exit clears the hunt bookkeeping.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state    <= S_HUNT;
      seen     <= '0;
      skew_cnt <= '0;
    end else if (hunt_align) begin
      state    <= S_ALIGNED;
      seen     <= '0;
      skew_cnt <= '0;
    end else if (hunt_err) begin
      seen     <= '0;
      skew_cnt <= '0;
    end else if (hunting && s_rx.valid && (|seen_nxt)) begin
      seen     <= seen_nxt;
      skew_cnt <= beat_skew;
    end else if (mismatch) begin
      state    <= S_HUNT;
    end
  end

  // Output valid follows the input beat by one cycle, suppressed on a mismatching beat.
  always_ff @(posedge aclk) begin
    if (areset) begin
      m_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      m_valid_q <= rd_en && !mismatch;
      err_q     <= hunt_err || mismatch;
    end
  end

  assign m_out.data  = out_data;
  assign m_out.k     = out_k;
  assign m_out.valid = m_valid_q;
  assign aligned     = (state == S_ALIGNED);
  assign deskew_err  = err_q;

endmodule

// File: tb/tb_pcie_7x_rx_lane_deskew.sv
// Scoreboard bench: each scenario pushes hand-derived aligned beats, a monitor pops on m_valid.
module tb_pcie_7x_rx_lane_deskew;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
  } beat_t;

  logic aclk = 1'b0;
  logic areset;
  logic aligned;
  logic deskew_err;

  always #5 aclk = ~aclk;

  pcie_7x_rx_lane_deskew_if #(.C_LANES(4)) rx_if ();
  pcie_7x_rx_lane_deskew_if #(.C_LANES(4)) tx_if ();

  pcie_7x_rx_lane_deskew #(
    .C_LANES    (4),
    .C_DEPTH    (8),
    .C_MAX_SKEW (4)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .s_rx       (rx_if),
    .m_out      (tx_if),
    .aligned    (aligned),
    .deskew_err (deskew_err)
  );

  int    checks   = 0;
  int    failures = 0;
  beat_t exp_q[$];

  logic [7:0] sd [40][4];
  logic       sk [40][4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: sample away from the active edge.
  logic v_smp, r_smp, err_prev;
  always @(posedge aclk) begin
    v_smp <= rx_if.valid;
    r_smp <= areset;
  end

  always @(negedge aclk) begin
    beat_t e;
    if (r_smp === 1'b0) begin
      if (tx_if.valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat actual data=%0h required no beat", tx_if.data);
        end else begin
          e = exp_q.pop_front();
          if (tx_if.data !== e.d || tx_if.k !== e.k) begin
            failures++;
            $display("FAIL m_beat actual=%0h/%0h required=%0h/%0h", tx_if.data, tx_if.k, e.d, e.k);
          end
        end
      end
      if (v_smp === 1'b0) chk("m_valid_idle", {63'd0, tx_if.valid}, 64'd0);
      if (deskew_err === 1'b1) begin
        chk("err_m_valid_low", {63'd0, tx_if.valid}, 64'd0);
        chk("err_width", {63'd0, err_prev}, 64'd0);
      end
    end
    err_prev = deskew_err;
  end

  function automatic logic [31:0] pd(input int b);
    logic [31:0] r;
    for (int n = 0; n < 4; n++) r[n*8 +: 8] = sd[b][n];
    return r;
  endfunction

  function automatic logic [3:0] pk(input int b);
    logic [3:0] r;
    for (int n = 0; n < 4; n++) r[n] = sk[b][n];
    return r;
  endfunction

  task automatic fill();
    for (int b = 0; b < 40; b++)
      for (int n = 0; n < 4; n++) begin
        sd[b][n] = 8'(b * 16 + n);
        sk[b][n] = 1'b0;
      end
  endtask

  task automatic setc(input int b, input int n);
    sd[b][n] = 8'hBC;
    sk[b][n] = 1'b1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] k, input logic r);
    rx_if.valid = v;
    rx_if.data  = d;
    rx_if.k     = k;
    areset      = r;
    @(posedge aclk);
    #1;
  endtask

  // Reset is applied with a live beat on the inputs; every output must clear on that edge.
  task automatic do_reset(input int sid);
    drive(1'b1, 32'h5A3C_1E0F, 4'h0, 1'b1);
    chk($sformatf("s%0d_rst_m_data", sid),  {32'd0, tx_if.data}, 64'd0);
    chk($sformatf("s%0d_rst_m_k", sid),     {60'd0, tx_if.k}, 64'd0);
    chk($sformatf("s%0d_rst_m_valid", sid), {63'd0, tx_if.valid}, 64'd0);
    chk($sformatf("s%0d_rst_aligned", sid), {63'd0, aligned}, 64'd0);
    chk($sformatf("s%0d_rst_err", sid),     {63'd0, deskew_err}, 64'd0);
  endtask

  // L: beat that completes alignment; al_end: last beat after which aligned is still high;
  // ea/eb: beats whose edge raises deskew_err; b0..b3: COM beat each lane is aligned to.
  task automatic run(input int sid, input int nbeats, input int L, input int al_end,
                     input int ea, input int eb, input int nexp, input bit gap,
                     input int b0, input int b1, input int b2, input int b3);
    int    base [4];
    beat_t e;
    logic  exp_al;
    base[0] = b0; base[1] = b1; base[2] = b2; base[3] = b3;
    do_reset(sid);
    for (int j = 0; j < nexp; j++) begin
      for (int n = 0; n < 4; n++) begin
        e.d[n*8 +: 8] = sd[base[n] + j][n];
        e.k[n]        = sk[base[n] + j][n];
      end
      exp_q.push_back(e);
    end
    for (int b = 0; b < nbeats; b++) begin
      if (gap) drive(1'b0, 32'hFFFF_FFFF, 4'hF, 1'b0);
      drive(1'b1, pd(b), pk(b), 1'b0);
      exp_al = (L >= 0) && (b >= L) && (b <= al_end);
      chk($sformatf("s%0d_aligned_b%0d", sid, b), {63'd0, aligned}, {63'd0, exp_al});
      chk($sformatf("s%0d_err_b%0d", sid, b), {63'd0, deskew_err},
          {63'd0, (b == ea) || (b == eb)});
      if (L >= 0 && nexp > 0 && b == L + 1) begin
        chk($sformatf("s%0d_first_m_valid", sid), {63'd0, tx_if.valid}, 64'd1);
        chk($sformatf("s%0d_first_m_k", sid), {60'd0, tx_if.k}, 64'hF);
        chk($sformatf("s%0d_first_m_data", sid), {32'd0, tx_if.data}, 64'hBCBC_BCBC);
      end
    end
    for (int i = 0; i < 4; i++) drive(1'b0, 32'd0, 4'h0, 1'b0);
    chk($sformatf("s%0d_exp_q_drained", sid), 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    rx_if.valid = 1'b0;
    rx_if.data  = '0;
    rx_if.k     = '0;
    areset      = 1'b1;
    drive(1'b0, 32'd0, 4'h0, 1'b1);

    // Zero skew: COM on all lanes at beat 10.
    fill();
    for (int n = 0; n < 4; n++) setc(10, n);
    run(1, 20, 10, 99, -1, -1, 9, 1'b0, 10, 10, 10, 10);

    // Skew 3: lanes 0..3 see COM at beats 10..13 (reset here lands mid-ALIGNED).
    fill();
    for (int n = 0; n < 4; n++) setc(10 + n, n);
    run(2, 24, 13, 99, -1, -1, 10, 1'b0, 10, 11, 12, 13);

    // Overflow: lane 3 late by 5; errors at 14 and at 19 (restarted hunt), clean set at 20.
    fill();
    for (int n = 0; n < 3; n++) setc(10, n);
    setc(15, 3);
    for (int n = 0; n < 4; n++) setc(20, n);
    run(3, 30, 20, 99, 14, 19, 9, 1'b0, 20, 20, 20, 20);

    // Skew 2 with a valid gap before every beat.
    fill();
    setc(10, 0); setc(10, 1); setc(12, 2); setc(12, 3);
    run(4, 24, 12, 99, -1, -1, 11, 1'b1, 10, 10, 12, 12);

    // Mismatch: aligned at 10, lone lane-0 COM at 15 is read out on beat 16.
    fill();
    for (int n = 0; n < 4; n++) setc(10, n);
    setc(15, 0);
    run(5, 22, 10, 15, 16, -1, 5, 1'b0, 10, 10, 10, 10);

    // Realignment after a mid-ALIGNED reset (scenario 5 ended in HUNT, so align first).
    fill();
    for (int n = 0; n < 4; n++) setc(10, n);
    run(6, 14, 10, 99, -1, -1, 3, 1'b0, 10, 10, 10, 10);
    fill();
    setc(11, 0); setc(12, 1); setc(12, 2); setc(11, 3);
    run(7, 20, 12, 99, -1, -1, 7, 1'b0, 11, 12, 12, 11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
